// File: rtl/div_hilo_if.sv
// ============================================================================
// Module      : div_hilo_if
// Description : EX-stage handshake/result bundle between the pipeline and the
//               multi-cycle DIV/DIVU unit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface div_hilo_if #(
   parameter int WIDTH = 32
);
   logic                 start_i;
   logic                 signed_i;
   logic                 cancel_i;
   logic [WIDTH-1:0]     a_i;
   logic [WIDTH-1:0]     b_i;
   logic                 stall_o;
   logic                 ready_o;
   logic [2*WIDTH-1:0]   hilo_o;

   modport master (
      output start_i, signed_i, cancel_i, a_i, b_i,
      input  stall_o, ready_o, hilo_o
   );

   modport slave (
      input  start_i, signed_i, cancel_i, a_i, b_i,
      output stall_o, ready_o, hilo_o
   );
endinterface

`default_nettype wire

// File: rtl/div_hilo_unit.sv
// ============================================================================
// Module      : div_hilo_unit
// Description : Multi-cycle restoring divider for MIPS DIV/DIVU, producing
//               {HI=remainder, LO=quotient} and stalling EX while busy.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  wire logic    clk,
   input  wire logic    resetn,
   div_hilo_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WIDTH - 1);

   state_t               r_state;
   state_t               w_state_nx;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_quot;
   logic [WIDTH-1:0]     r_div;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [2*WIDTH-1:0]   r_hilo;

   logic                 w_accept;
   logic                 w_b_zero;
   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_abs;
   logic [WIDTH-1:0]     w_b_abs;
   logic [WIDTH:0]       w_trial;
   logic                 w_borrow;
   logic [WIDTH-1:0]     w_rem_nx;
   logic [WIDTH-1:0]     w_quot_nx;
   logic [WIDTH-1:0]     w_q_fin;
   logic [WIDTH-1:0]     w_r_fin;

   // Operand conditioning: magnitudes only for signed divides.
   assign w_accept = bus.start_i && !bus.cancel_i;
   assign w_b_zero = (bus.b_i == '0);
   assign w_a_neg  = bus.signed_i && bus.a_i[WIDTH-1];
   assign w_b_neg  = bus.signed_i && bus.b_i[WIDTH-1];
   assign w_a_abs  = w_a_neg ? (~bus.a_i + 1'b1) : bus.a_i;
   assign w_b_abs  = w_b_neg ? (~bus.b_i + 1'b1) : bus.b_i;

   // One restoring step; the partial remainder stays below |b|, so the
   // (WIDTH+1)-bit difference sign bit is the borrow.
   assign w_trial   = {r_rem, r_quot[WIDTH-1]} - {1'b0, r_div};
   assign w_borrow  = w_trial[WIDTH];
   assign w_rem_nx  = w_borrow ? {r_rem[WIDTH-2:0], r_quot[WIDTH-1]} : w_trial[WIDTH-1:0];
   assign w_quot_nx = {r_quot[WIDTH-2:0], ~w_borrow};

   assign w_q_fin = r_neg_q ? (~w_quot_nx + 1'b1) : w_quot_nx;
   assign w_r_fin = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nx = w_b_zero ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (bus.cancel_i) begin
               w_state_nx = S_IDLE;
            end else if (r_cnt == c_LAST_STEP) begin
               w_state_nx = S_DONE;
            end
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quot  <= '0;
         r_div   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_hilo  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_b_zero) begin
                     r_hilo <= {bus.a_i, {WIDTH{1'b1}}};
                  end else begin
                     r_cnt   <= '0;
                     r_rem   <= '0;
                     r_quot  <= w_a_abs;
                     r_div   <= w_b_abs;
                     r_neg_q <= w_a_neg ^ w_b_neg;
                     r_neg_r <= w_a_neg;
                  end
               end
            end
            S_BUSY: begin
               if (!bus.cancel_i) begin
                  r_cnt  <= r_cnt + 1'b1;
                  r_rem  <= w_rem_nx;
                  r_quot <= w_quot_nx;
                  if (r_cnt == c_LAST_STEP) begin
                     r_hilo <= {w_r_fin, w_q_fin};
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.stall_o = ((r_state == S_IDLE) && bus.start_i) || (r_state == S_BUSY);
   assign bus.ready_o = (r_state == S_DONE) && !bus.cancel_i;
   assign bus.hilo_o  = r_hilo;

endmodule

`default_nettype wire

// File: tb/tb_div_hilo_unit.sv
// ============================================================================
// Module      : tb_div_hilo_unit
// Description : Scoreboard bench for div_hilo_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_hilo_unit;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   div_hilo_if #(.WIDTH(32)) bus ();

   div_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] sb[$];
   logic [63:0] last_hilo = 64'h0;

   // Architectural result: HI = remainder, LO = quotient, truncating division.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint na, nb, q, r;
      if (b == 32'h0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         na = longint'($signed(a));
         nb = longint'($signed(b));
      end else begin
         na = longint'({32'h0, a});
         nb = longint'({32'h0, b});
      end
      q = na / nb;
      r = na % nb;
      return {r[31:0], q[31:0]};
   endfunction

   always @(negedge clk) begin
      if (resetn && bus.ready_o) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_ready: hilo_o=%h, no result expected", bus.hilo_o);
         end else begin
            logic [63:0] exp_v;
            exp_v = sb.pop_front();
            last_hilo = exp_v;
            if (bus.hilo_o !== exp_v) begin
               n_fail++;
               $display("FAIL hilo_result: got %h, expected %h", bus.hilo_o, exp_v);
            end
         end
      end
   end

   task automatic do_reset();
      resetn       = 1'b0;
      bus.start_i  = 1'b0;
      bus.cancel_i = 1'b0;
      sb.delete();
      last_hilo    = 64'h0;
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 of the IDLE cycle after DONE.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      int cyc;
      int exp_lat;
      bit stall_ok;
      bit timeout;
      bus.start_i  = 1'b1;
      bus.signed_i = sgn;
      bus.a_i      = a;
      bus.b_i      = b;
      sb.push_back(ref_div(a, b, sgn));
      exp_lat  = (b == 32'h0) ? 1 : 33;
      cyc      = 0;
      stall_ok = 1'b1;
      timeout  = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.ready_o) begin
            if (bus.stall_o) stall_ok = 1'b0;
            break;
         end
         if (!bus.stall_o) stall_ok = 1'b0;
         if (cyc >= 1) begin
            bus.a_i      = $urandom;
            bus.b_i      = $urandom;
            bus.signed_i = 1'($urandom_range(0, 1));
         end
         if (cyc >= 40) begin
            timeout = 1'b1;
            break;
         end
         cyc++;
      end
      n_tests++;
      if (timeout) begin
         n_fail++;
         $display("FAIL ready_timeout: a=%h b=%h s=%0d no ready_o within 40 cycles", a, b, sgn);
         do_reset();
      end else begin
         if (cyc != exp_lat || !stall_ok) begin
            n_fail++;
            $display("FAIL latency_stall: a=%h b=%h ready at cycle %0d (stall ok=%0d), expected cycle %0d (stall ok=1)",
                     a, b, cyc, stall_ok, exp_lat);
         end
         @(posedge clk);
         #1 bus.start_i = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      bus.start_i  = 1'b0;
      bus.signed_i = 1'b0;
      bus.cancel_i = 1'b0;
      bus.a_i      = 32'h0;
      bus.b_i      = 32'h0;
      resetn       = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.ready_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.hilo_o !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_state: ready=%b stall=%b hilo=%h, expected 0 0 0",
                  bus.ready_o, bus.stall_o, bus.hilo_o);
      end
      @(posedge clk);
      #1 resetn = 1'b1;

      run_op(32'd100, 32'd7, 1'b0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
      run_op(32'd5, 32'd0, 1'b0);
      run_op(32'h8000_0000, 32'd0, 1'b1);

      // Cancel mid-divide: start in cycle 0, cancel in cycle 10, restart in cycle 12.
      @(posedge clk);
      #1;
      bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.a_i = 32'd1000; bus.b_i = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      bus.cancel_i = 1'b1;
      bus.start_i  = 1'b0;
      @(posedge clk);
      #1 bus.cancel_i = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.stall_o !== 1'b0 || bus.hilo_o !== last_hilo) begin
         n_fail++;
         $display("FAIL cancel_idle: stall=%b hilo=%h, expected stall=0 hilo=%h",
                  bus.stall_o, bus.hilo_o, last_hilo);
      end
      @(posedge clk);
      #1 run_op(32'd1000, 32'd3, 1'b0);

      // Reset mid-divide at cycle 20.
      bus.start_i = 1'b1; bus.signed_i = 1'b1; bus.a_i = 32'hFFFF_0000; bus.b_i = 32'd9;
      repeat (20) @(posedge clk);
      #1;
      resetn      = 1'b0;
      bus.start_i = 1'b0;
      #1;
      n_tests++;
      if (bus.ready_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.hilo_o !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_mid_divide: ready=%b stall=%b hilo=%h, expected 0 0 0",
                  bus.ready_o, bus.stall_o, bus.hilo_o);
      end
      last_hilo = 64'h0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      run_op(32'hFFFF_0000, 32'd9, 1'b1);

      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 9))
            0:       rb = 32'h0;
            1:       rb = 32'h1;
            2:       rb = 32'hFFFF_FFFF;
            3:       rb = $urandom >> $urandom_range(16, 31);
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         case ($urandom_range(0, 9))
            0:       ra = 32'h8000_0000;
            1:       ra = $urandom >> $urandom_range(20, 31);
            default: ra = $urandom;
         endcase
         run_op(ra, rb, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (5) @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
